vproc_dispatcher: RTL and testbench
===================================

// Module: vproc_dispatcher
// PURPOSE
//  Single-entry issue stage between the vector decoder and the five execution units (LSU, ALU, MUL,
//  SLD, ELEM). Holds one decoded instruction, checks it against a pending-vreg-write scoreboard
//  (RAW/WAW), routes it to its unit via valid/ready, and treats UNIT_CFG as a drain barrier.
//  WAR hazards are resolved downstream by the units' pending-read logic and are not tracked here.
// PARAMETERS
//  UNIT_CNT  5   execution units; index = op_unit encoding (LSU=0 ALU=1 MUL=2 SLD=3 ELEM=4)
//  VREG_CNT  32  vector registers tracked by the scoreboard
//  ID_W      3   instruction id width, passed through unchanged
// PORTS
//  clk_i            in   1                  clock
//  async_rst_i      in   1                  asynchronous reset, active-high
//  instr_valid_i    in   1                  decoded instruction valid
//  instr_ready_o    out  1                  dispatcher accepts instruction this cycle
//  instr_unit_i     in   3                  op_unit code (0-4 units, 5 UNIT_CFG, 6-7 illegal)
//  instr_id_i       in   ID_W               instruction id
//  instr_vd_i       in   VREG_CNT           one-hot/multi-hot vregs written (LMUL group; 0 if none)
//  instr_vs_i       in   VREG_CNT           vregs read (incl. v0 if masked)
//  disp_valid_o     out  UNIT_CNT           one-hot dispatch request
//  disp_ready_i     in   UNIT_CNT           per-unit accept
//  disp_id_o        out  ID_W               id of dispatched instruction
//  done_clear_i     in   UNIT_CNT*VREG_CNT  per-unit vregs whose write completed this cycle
//  cfg_valid_o      out  1                  one-cycle pulse: CFG instruction retired
//  err_o            out  1                  one-cycle pulse: illegal unit code dropped
//  busy_o           out  1                  buffer occupied or any pending write
// BEHAVIOUR
//  - Reset: buf_valid=0, pend_q=0, disp_valid_o=0, cfg_valid_o=0, err_o=0, busy_o=0, instr_ready_o=1.
//    Reset mid-operation discards the buffered instruction and all pending bits.
//  - Buffer (FSM EMPTY/HOLD): instr_ready_o = !buf_valid | leave, where leave = dispatch fire,
//    cfg retire or illegal drop. Accept when instr_valid_i & instr_ready_o; captured fields go to
//    HOLD next cycle. Leave and accept in same cycle: HOLD->HOLD with new entry (back-to-back, 1/cycle).
//  - Latency: accepted in cycle N -> earliest disp_valid_o/cfg_valid_o/err_o in cycle N+1.
//  - clr = OR over units of done_clear_i slices; eff_pend = pend_q & ~clr (same-cycle bypass).
//  - hazard = |((buf_vs | buf_vd) & eff_pend).
//  - Unit instr (0-4): disp_valid_o[unit] = HOLD & !hazard; fire = disp_valid_o[unit] & disp_ready_i[unit].
//    Once asserted, disp_valid_o and disp_id_o remain stable until fire (hazard cannot reappear
//    since only this block sets pend bits).
//  - CFG (5): retires when HOLD & eff_pend==0; cfg_valid_o=1 that cycle only; no disp_valid_o.
//  - Illegal (6,7): err_o=1 in the first HOLD cycle, entry dropped, scoreboard untouched.
//  - pend_d = eff_pend | (fire ? buf_vd : 0); set wins over clear on same bit.
//    Clearing an already-clear bit is a no-op.
//  - disp_valid_o, cfg_valid_o, err_o are combinational from registered state plus
//    disp_ready_i/done_clear_i bypass.
//  - busy_o = buf_valid | (|pend_q).
// TESTING
//  1. LSU vd=0x10 accepted c0 -> disp_valid_o=5'b00001 c1 (ready=1); pend_q=0x10 c2; then ALU vs=0x100 dispatches c2.
//  2. pend_q=0x10, ALU vs=0x10 -> held; done_clear_i[LSU] bit4 at c5 -> disp_valid_o[1]=1 in c5, pend_q=0 c6.
//  3. MUL instr id=3, disp_ready_i[2]=0 for 3 cycles -> disp_valid_o[2]=1, disp_id_o=3 stable, instr_ready_o=0; fires cycle 4.
//  4. pend_q=0x0F00, CFG instr -> no pulses; clear of bits 8-11 at c7 -> cfg_valid_o=1 in c7 only, pend_q=0.
//  5. unit=3'b110 accepted c0 -> err_o=1 c1, instr_ready_o=1 c1, pend_q unchanged, disp_valid_o=0.
//  6. async_rst_i pulsed mid-HOLD with pend_q=0xFF -> outputs 0, pend_q=0, instr_ready_o=1 immediately.

Source files
------------

// File: rtl/vproc_dispatcher_if.sv
// vproc_dispatcher_if: decoder-side instruction handshake, unit dispatch and completion/status signals.
interface vproc_dispatcher_if #(
  parameter int UNIT_CNT = 5,
  parameter int VREG_CNT = 32,
  parameter int ID_W     = 3
);
  logic                         instr_valid_i;
  logic                         instr_ready_o;
  logic [2:0]                   instr_unit_i;
  logic [ID_W-1:0]              instr_id_i;
  logic [VREG_CNT-1:0]          instr_vd_i;
  logic [VREG_CNT-1:0]          instr_vs_i;
  logic [UNIT_CNT-1:0]          disp_valid_o;
  logic [UNIT_CNT-1:0]          disp_ready_i;
  logic [ID_W-1:0]              disp_id_o;
  logic [UNIT_CNT*VREG_CNT-1:0] done_clear_i;
  logic                         cfg_valid_o;
  logic                         err_o;
  logic                         busy_o;

  modport slave (
    input  instr_valid_i, instr_unit_i, instr_id_i, instr_vd_i, instr_vs_i, disp_ready_i, done_clear_i,
    output instr_ready_o, disp_valid_o, disp_id_o, cfg_valid_o, err_o, busy_o
  );

  modport master (
    output instr_valid_i, instr_unit_i, instr_id_i, instr_vd_i, instr_vs_i, disp_ready_i, done_clear_i,
    input  instr_ready_o, disp_valid_o, disp_id_o, cfg_valid_o, err_o, busy_o
  );
endinterface

// File: rtl/vproc_dispatcher.sv
// vproc_dispatcher: single-entry vector issue stage with RAW/WAW pending-write scoreboard and CFG drain barrier.
module vproc_dispatcher #(
  parameter int UNIT_CNT = 5,
  parameter int VREG_CNT = 32,
  parameter int ID_W     = 3
) (
  input logic               clk_i,
  input logic               async_rst_i,
  vproc_dispatcher_if.slave bus
);
  typedef enum logic {EMPTY, HOLD} state_e;
  state_e              state_q, state_d;
  logic [2:0]          unit_q;
  logic [ID_W-1:0]     id_q;
  logic [VREG_CNT-1:0] vd_q, vs_q, pend_q, pend_d, clr, eff_pend;
  logic [UNIT_CNT-1:0] disp_valid;
  logic                hold, hazard, fire, cfg_ret, ill, leave, accept;

  always_comb begin
    clr = '0;
    for (int u = 0; u < UNIT_CNT; u++) clr = clr | bus.done_clear_i[u*VREG_CNT +: VREG_CNT];
  end

  // completions in the current cycle are visible immediately so a waiting entry need not stall an extra cycle
  assign eff_pend = pend_q & ~clr;
  assign hold     = state_q == HOLD;
  assign hazard   = |((vs_q | vd_q) & eff_pend);

  always_comb begin
    disp_valid = (hold && unit_q < 3'(UNIT_CNT) && !hazard) ? UNIT_CNT'(1) << unit_q : '0;
    fire       = |(disp_valid & bus.disp_ready_i);
    cfg_ret    = hold && unit_q == 3'(UNIT_CNT) && eff_pend == '0;
    ill        = hold && unit_q > 3'(UNIT_CNT);
    leave      = fire | cfg_ret | ill;
    accept     = bus.instr_valid_i & (!hold | leave);
    state_d    = accept ? HOLD : (leave ? EMPTY : state_q);
    pend_d     = eff_pend | (fire ? vd_q : '0);
  end

  assign bus.instr_ready_o = !hold | leave;
  assign bus.disp_valid_o  = disp_valid;
  assign bus.disp_id_o     = id_q;
  assign bus.cfg_valid_o   = cfg_ret;
  assign bus.err_o         = ill;
  assign bus.busy_o        = hold | (|pend_q);

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= EMPTY;
      pend_q  <= '0;
      unit_q  <= '0;
      id_q    <= '0;
      vd_q    <= '0;
      vs_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        unit_q <= bus.instr_unit_i;
        id_q   <= bus.instr_id_i;
        vd_q   <= bus.instr_vd_i;
        vs_q   <= bus.instr_vs_i;
      end
    end
  end
endmodule

// File: tb/tb_vproc_dispatcher.sv
// tb_vproc_dispatcher: directed vectors for issue, hazards, backpressure, CFG drain, illegal drop and async reset.
module tb_vproc_dispatcher;
  localparam int UC = 5, VC = 32, IW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;

  vproc_dispatcher_if #(.UNIT_CNT(UC), .VREG_CNT(VC), .ID_W(IW)) bus ();
  vproc_dispatcher #(.UNIT_CNT(UC), .VREG_CNT(VC), .ID_W(IW)) dut (.clk_i(clk), .async_rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic instr(input logic v, input logic [2:0] u, input logic [IW-1:0] id,
                       input logic [VC-1:0] vd, input logic [VC-1:0] vs);
    bus.instr_valid_i = v;
    bus.instr_unit_i  = u;
    bus.instr_id_i    = id;
    bus.instr_vd_i    = vd;
    bus.instr_vs_i    = vs;
  endtask

  task automatic clear(input int u, input logic [VC-1:0] m);
    bus.done_clear_i = '0;
    bus.done_clear_i[u*VC +: VC] = m;
  endtask

  initial begin
    instr(0, 0, 0, 0, 0);
    bus.disp_ready_i = '1;
    bus.done_clear_i = '0;
    smp;
    chk("rst_ready", 64'(bus.instr_ready_o), 1);
    chk("rst_disp", 64'(bus.disp_valid_o), 0);
    chk("rst_cfg", 64'(bus.cfg_valid_o), 0);
    chk("rst_err", 64'(bus.err_o), 0);
    chk("rst_busy", 64'(bus.busy_o), 0);
    chk("rst_pend", 64'(dut.pend_q), 0);
    nxt;
    rst = 1'b0;
    // 1: LSU dispatch then independent ALU back-to-back
    instr(1, 0, 1, 32'h10, 0);
    smp;
    chk("t1_c0_ready", 64'(bus.instr_ready_o), 1);
    chk("t1_c0_disp", 64'(bus.disp_valid_o), 0);
    nxt;
    instr(1, 1, 2, 0, 32'h100);
    smp;
    chk("t1_c1_disp", 64'(bus.disp_valid_o), 5'b00001);
    chk("t1_c1_id", 64'(bus.disp_id_o), 1);
    chk("t1_c1_ready", 64'(bus.instr_ready_o), 1);
    nxt;
    instr(0, 0, 0, 0, 0);
    smp;
    chk("t1_c2_disp", 64'(bus.disp_valid_o), 5'b00010);
    chk("t1_c2_id", 64'(bus.disp_id_o), 2);
    chk("t1_c2_pend", 64'(dut.pend_q), 32'h10);
    nxt;
    // 2: RAW hazard on v4 released by same-cycle LSU completion
    instr(1, 1, 5, 0, 32'h10);
    smp;
    chk("t2_c3_busy", 64'(bus.busy_o), 1);
    nxt;
    instr(0, 0, 0, 0, 0);
    smp;
    chk("t2_c4_disp", 64'(bus.disp_valid_o), 0);
    chk("t2_c4_ready", 64'(bus.instr_ready_o), 0);
    nxt;
    clear(0, 32'h10);
    smp;
    chk("t2_c5_disp", 64'(bus.disp_valid_o), 5'b00010);
    chk("t2_c5_id", 64'(bus.disp_id_o), 5);
    nxt;
    bus.done_clear_i = '0;
    smp;
    chk("t2_c6_pend", 64'(dut.pend_q), 0);
    chk("t2_c6_disp", 64'(bus.disp_valid_o), 0);
    chk("t2_c6_busy", 64'(bus.busy_o), 0);
    nxt;
    // 3: MUL backpressured for 3 cycles
    bus.disp_ready_i = 5'b11011;
    instr(1, 2, 3, 32'h0F00, 0);
    nxt;
    instr(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      smp;
      chk("t3_stall_disp", 64'(bus.disp_valid_o), 5'b00100);
      chk("t3_stall_id", 64'(bus.disp_id_o), 3);
      chk("t3_stall_ready", 64'(bus.instr_ready_o), 0);
      nxt;
    end
    bus.disp_ready_i = '1;
    smp;
    chk("t3_fire_disp", 64'(bus.disp_valid_o), 5'b00100);
    chk("t3_fire_ready", 64'(bus.instr_ready_o), 1);
    nxt;
    // 4: CFG waits for drain of v8-v11
    instr(1, 5, 4, 0, 0);
    smp;
    chk("t4_c5_pend", 64'(dut.pend_q), 32'h0F00);
    nxt;
    instr(0, 0, 0, 0, 0);
    smp;
    chk("t4_c6_cfg", 64'(bus.cfg_valid_o), 0);
    chk("t4_c6_disp", 64'(bus.disp_valid_o), 0);
    chk("t4_c6_ready", 64'(bus.instr_ready_o), 0);
    nxt;
    clear(2, 32'h0F00);
    smp;
    chk("t4_c7_cfg", 64'(bus.cfg_valid_o), 1);
    chk("t4_c7_disp", 64'(bus.disp_valid_o), 0);
    chk("t4_c7_ready", 64'(bus.instr_ready_o), 1);
    nxt;
    bus.done_clear_i = '0;
    smp;
    chk("t4_c8_cfg", 64'(bus.cfg_valid_o), 0);
    chk("t4_c8_pend", 64'(dut.pend_q), 0);
    chk("t4_c8_busy", 64'(bus.busy_o), 0);
    nxt;
    // 5: illegal unit code dropped
    instr(1, 6, 6, 32'h3, 32'h3);
    nxt;
    instr(0, 0, 0, 0, 0);
    smp;
    chk("t5_err", 64'(bus.err_o), 1);
    chk("t5_ready", 64'(bus.instr_ready_o), 1);
    chk("t5_disp", 64'(bus.disp_valid_o), 0);
    nxt;
    smp;
    chk("t5_err_gone", 64'(bus.err_o), 0);
    chk("t5_pend", 64'(dut.pend_q), 0);
    chk("t5_busy", 64'(bus.busy_o), 0);
    nxt;
    // 6: set wins over same-cycle clear, then async reset mid-HOLD
    instr(1, 1, 7, 32'hFF, 0);
    nxt;
    instr(1, 3, 1, 0, 32'h1);
    clear(0, 32'h1);
    smp;
    chk("t6_disp", 64'(bus.disp_valid_o), 5'b00010);
    nxt;
    instr(0, 0, 0, 0, 0);
    bus.done_clear_i = '0;
    smp;
    chk("t6_pend", 64'(dut.pend_q), 32'hFF);
    chk("t6_hold_disp", 64'(bus.disp_valid_o), 0);
    chk("t6_hold_ready", 64'(bus.instr_ready_o), 0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(bus.instr_ready_o), 1);
    chk("t6_rst_disp", 64'(bus.disp_valid_o), 0);
    chk("t6_rst_pend", 64'(dut.pend_q), 0);
    chk("t6_rst_busy", 64'(bus.busy_o), 0);
    nxt;
    rst = 1'b0;
    smp;
    chk("t6_post_disp", 64'(bus.disp_valid_o), 0);
    chk("t6_post_busy", 64'(bus.busy_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
